sccb_arbiter: RTL and testbench
===============================

SCCB_ARBITER -- requirements
Module: sccb_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 20'd500000, meaning BUSY-state cycles allowed before abort (used only with SCCB_ARB_TIMEOUT_EN).
REQ-002 SHALL have port i_clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port i_rstn  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port i_req0  input  1  requester 0 (config sequencer) write request, level.
REQ-005 SHALL have port i_addr_data0  input  16  requester 0 {reg_addr[15:8], reg_data[7:0]}.
REQ-006 SHALL have port o_ack0  output  1  one-cycle pulse, requester 0 transaction finished.
REQ-007 SHALL have port i_req1  input  1  requester 1 (runtime host tweaks) write request, level.
REQ-008 SHALL have port i_addr_data1  input  16  requester 1 {reg_addr, reg_data}.
REQ-009 SHALL have port o_ack1  output  1  one-cycle pulse, requester 1 transaction finished.
REQ-010 SHALL have port o_wr_en  output  1  level start/hold to SCCB write engine.
REQ-011 SHALL have port o_reg_addr  output  8  register address to engine.
REQ-012 SHALL have port o_reg_data  output  8  register data to engine.
REQ-013 SHALL have port i_wr_done  input  1  one-cycle pulse from engine, write complete.
REQ-014 SHALL have port o_busy  output  1  high while not IDLE.
REQ-015 SHALL have port o_owner  output  1  index of granted requester, valid while o_busy.
REQ-016 SHALL have port o_err  output  1  one-cycle pulse coincident with o_ack0/o_ack1 when transaction aborted.

Function
REQ-017 SHALL implement states IDLE, BUSY, DONE.
REQ-018 IDLE: if any i_reqN high, SHALL latch winner's i_addr_dataN into o_reg_addr/o_reg_data, set o_owner, enter BUSY next cycle (grant latency 1 cycle).
REQ-019 Simultaneous i_req0 and i_req1 SHALL be resolved by round-robin pointer; pointer SHALL move to the other requester after each DONE.
REQ-020 Single requester SHALL be granted regardless of pointer.
REQ-021 BUSY: o_wr_en SHALL be 1; o_reg_addr/o_reg_data SHALL be stable; i_reqN and i_addr_dataN changes SHALL be ignored.
REQ-022 BUSY with i_wr_done=1 SHALL enter DONE next cycle.
REQ-023 DONE: o_wr_en SHALL be 0, o_ackN for o_owner SHALL be 1 for exactly one cycle, next state IDLE unconditionally (min 1-cycle o_wr_en gap between transactions).
REQ-024 i_wr_done in IDLE or DONE SHALL be ignored.
REQ-025 Requester SHALL hold i_reqN and data stable until o_ackN; i_reqN still high in the IDLE cycle after DONE SHALL count as a new request.
REQ-026 Back-to-back throughput SHALL be one transaction per (engine time + 2) cycles.
REQ-027 o_ack0 and o_ack1 SHALL never be high in the same cycle.

Reset
REQ-028 i_rstn low SHALL asynchronously force state IDLE, pointer to requester 0, timeout counter 0, and all outputs (o_wr_en, o_ack0, o_ack1, o_err, o_busy, o_owner, o_reg_addr, o_reg_data) to 0.
REQ-029 Reset during BUSY SHALL drop o_wr_en immediately with no o_ackN issued; interrupted request SHALL be re-arbitrated after release if i_reqN still high.

Configuration
REQ-030 Macro SCCB_ARB_TIMEOUT_EN defined: counter SHALL clear on BUSY entry, increment each BUSY cycle; reaching TIMEOUT_CYCLES without i_wr_done SHALL enter DONE with o_err=1 alongside o_ackN.
REQ-031 i_wr_done in the same cycle as counter expiry SHALL take precedence (o_err=0).
REQ-032 Macro undefined: no counter logic, o_err tied 0, BUSY waits indefinitely for i_wr_done.

Verification
REQ-033 i_req0=1, addr_data0=16'h1280, engine done 10 cycles after o_wr_en -> o_wr_en at cycle+1, o_reg_addr=8'h12, o_reg_data=8'h80, o_ack0 pulse 1 cycle after i_wr_done, o_err=0.
REQ-034 i_req0 and i_req1 both held high for 4 transactions -> grant order 0,1,0,1; o_wr_en low one cycle between each.
REQ-035 i_addr_data0 changed 16'h1280->16'h3A04 mid-BUSY -> engine outputs remain 8'h12/8'h80 until DONE.
REQ-036 i_rstn low 3 cycles into BUSY -> o_wr_en=0 asynchronously, no o_ack0; after release with i_req0 high, fresh grant to requester 0.
REQ-037 With SCCB_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16, no i_wr_done -> o_ack1 and o_err pulse together 17 cycles after BUSY entry; i_wr_done on expiry cycle -> o_err=0.
REQ-038 Stray i_wr_done pulse in IDLE -> no state change, no ack.

Source files
------------

// File: rtl/sccb_arbiter.sv
// rtl/sccb_arbiter.sv - two-requester arbiter in front of an SCCB register write engine
//
// Grants one of two register-write requesters to a single SCCB write engine.
// Simultaneous requests are resolved round-robin; the pointer flips to the
// other requester after every completed transaction.
//
// Optional feature: define SCCB_ARB_TIMEOUT_EN to abort a BUSY transaction
// after TIMEOUT_CYCLES cycles without i_wr_done (flagged by o_err).
//
// Ports:
//   i_clk, i_rstn        clock, asynchronous active-low reset
//   i_req0/i_req1        level write requests
//   i_addr_data0/1       {reg_addr[15:8], reg_data[7:0]} per requester
//   o_ack0/o_ack1        one-cycle completion pulse to the owning requester
//   o_wr_en              start/hold level to the write engine
//   o_reg_addr/data      latched register address/data to the engine
//   i_wr_done            one-cycle completion pulse from the engine
//   o_busy               high while not IDLE
//   o_owner              granted requester index, valid while o_busy
//   o_err                pulse alongside o_ackN when the transaction timed out

module sccb_arbiter #(
  parameter logic [19:0] TIMEOUT_CYCLES = 20'd500000
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic        i_req0,
  input  logic [15:0] i_addr_data0,
  output logic        o_ack0,
  input  logic        i_req1,
  input  logic [15:0] i_addr_data1,
  output logic        o_ack1,
  output logic        o_wr_en,
  output logic [7:0]  o_reg_addr,
  output logic [7:0]  o_reg_data,
  input  logic        i_wr_done,
  output logic        o_busy,
  output logic        o_owner,
  output logic        o_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, next_state;
  logic   ptr;
  logic   owner;
  logic   grant1;
  logic   timeout_hit;
  logic   err_q;

  // Requester 1 wins when it is the only one asking, or both ask and the
  // round-robin pointer favours it.
  assign grant1 = i_req1 & (~i_req0 | ptr);

`ifdef SCCB_ARB_TIMEOUT_EN
  logic [19:0] cnt;

  // cnt holds the number of BUSY cycles already spent before this one, so the
  // abort decision lands on the (TIMEOUT_CYCLES+1)-th BUSY cycle.
  assign timeout_hit = (state == BUSY) && (cnt == TIMEOUT_CYCLES);

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      cnt   <= 20'd0;
      err_q <= 1'b0;
    end else begin
      if (state == BUSY) begin
        cnt <= cnt + 20'd1;
      end else begin
        cnt <= 20'd0;
      end
      // A real completion in the expiry cycle wins over the timeout.
      if (state == BUSY && next_state == DONE) begin
        err_q <= ~i_wr_done;
      end else if (state == DONE) begin
        err_q <= 1'b0;
      end
    end
  end
`else
  wire unused_timeout = ^TIMEOUT_CYCLES;
  assign timeout_hit = 1'b0;
  assign err_q       = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state      <= IDLE;
      ptr        <= 1'b0;
      owner      <= 1'b0;
      o_reg_addr <= 8'h00;
      o_reg_data <= 8'h00;
    end else begin
      state <= next_state;
      if (state == IDLE && (i_req0 || i_req1)) begin
        owner <= grant1;
        if (grant1) begin
          o_reg_addr <= i_addr_data1[15:8];
          o_reg_data <= i_addr_data1[7:0];
        end else begin
          o_reg_addr <= i_addr_data0[15:8];
          o_reg_data <= i_addr_data0[7:0];
        end
      end
      if (state == DONE) begin
        ptr <= ~owner;
      end
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (i_req0 || i_req1) next_state = BUSY;
      end
      BUSY: begin
        if (i_wr_done || timeout_hit) next_state = DONE;
      end
      DONE: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Outputs decode straight from state so reset removes o_wr_en at once.
  always_comb begin
    o_wr_en = 1'b0;
    o_ack0  = 1'b0;
    o_ack1  = 1'b0;
    o_err   = 1'b0;
    o_busy  = 1'b0;
    o_owner = owner;
    case (state)
      BUSY: begin
        o_wr_en = 1'b1;
        o_busy  = 1'b1;
      end
      DONE: begin
        o_busy = 1'b1;
        o_ack0 = ~owner;
        o_ack1 = owner;
        o_err  = err_q;
      end
      default: begin
        o_wr_en = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_sccb_arbiter.sv
// tb/tb_sccb_arbiter.sv - directed self-checking bench for sccb_arbiter

module tb_sccb_arbiter;

  logic        clk;
  logic        rstn;
  logic        req0;
  logic [15:0] ad0;
  logic        ack0;
  logic        req1;
  logic [15:0] ad1;
  logic        ack1;
  logic        wr_en;
  logic [7:0]  reg_addr;
  logic [7:0]  reg_data;
  logic        wr_done;
  logic        busy;
  logic        owner;
  logic        err;

  int total;
  int bad;

  sccb_arbiter #(.TIMEOUT_CYCLES(20'd16)) dut (
    .i_clk       (clk),
    .i_rstn      (rstn),
    .i_req0      (req0),
    .i_addr_data0(ad0),
    .o_ack0      (ack0),
    .i_req1      (req1),
    .i_addr_data1(ad1),
    .o_ack1      (ack1),
    .o_wr_en     (wr_en),
    .o_reg_addr  (reg_addr),
    .o_reg_data  (reg_data),
    .i_wr_done   (wr_done),
    .o_busy      (busy),
    .o_owner     (owner),
    .o_err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    req0 = 1'b0; req1 = 1'b0; ad0 = 16'h0; ad1 = 16'h0; wr_done = 1'b0;
    rstn = 1'b0;
    tick();
    total++;
    if ({wr_en, ack0, ack1, err, busy, owner, reg_addr, reg_data} !== 22'd0) begin
      bad++;
      $display("FAIL reset_outputs: got %b expected all zero",
               {wr_en, ack0, ack1, err, busy, owner, reg_addr, reg_data});
    end
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_single();
    int stable_bad;
    stable_bad = 0;
    req0 = 1'b1; ad0 = 16'h1280;
    tick();
    total++;
    if (wr_en !== 1'b1 || reg_addr !== 8'h12 || reg_data !== 8'h80 || busy !== 1'b1 || owner !== 1'b0) begin
      bad++;
      $display("FAIL single_grant: wr_en=%b addr=%h data=%h busy=%b owner=%b expected 1 12 80 1 0",
               wr_en, reg_addr, reg_data, busy, owner);
    end
    ad0 = 16'h3A04;
    for (int i = 0; i < 9; i++) begin
      tick();
      if (wr_en !== 1'b1 || reg_addr !== 8'h12 || reg_data !== 8'h80 || ack0 !== 1'b0) stable_bad++;
    end
    total++;
    if (stable_bad != 0) begin
      bad++;
      $display("FAIL busy_stable: %0d bad BUSY cycles expected 0", stable_bad);
    end
    wr_done = 1'b1;
    tick();
    wr_done = 1'b0;
    total++;
    if (ack0 !== 1'b1 || ack1 !== 1'b0 || err !== 1'b0 || wr_en !== 1'b0) begin
      bad++;
      $display("FAIL single_done: ack0=%b ack1=%b err=%b wr_en=%b expected 1 0 0 0", ack0, ack1, err, wr_en);
    end
    req0 = 1'b0;
    tick();
    total++;
    if (ack0 !== 1'b0 || busy !== 1'b0 || wr_en !== 1'b0) begin
      bad++;
      $display("FAIL single_idle: ack0=%b busy=%b wr_en=%b expected 0 0 0", ack0, busy, wr_en);
    end
  endtask

  task automatic test_stray_done();
    wr_done = 1'b1;
    tick();
    wr_done = 1'b0;
    total++;
    if (busy !== 1'b0 || wr_en !== 1'b0 || ack0 !== 1'b0 || ack1 !== 1'b0) begin
      bad++;
      $display("FAIL stray_done: busy=%b wr_en=%b ack0=%b ack1=%b expected 0 0 0 0", busy, wr_en, ack0, ack1);
    end
    tick();
    total++;
    if (busy !== 1'b0 || ack0 !== 1'b0 || ack1 !== 1'b0) begin
      bad++;
      $display("FAIL stray_after: busy=%b ack0=%b ack1=%b expected 0 0 0", busy, ack0, ack1);
    end
  endtask

  task automatic test_reset_busy();
    req0 = 1'b1; ad0 = 16'h5566;
    tick();
    tick();
    tick();
    total++;
    if (wr_en !== 1'b1) begin
      bad++;
      $display("FAIL rb_busy: wr_en=%b expected 1", wr_en);
    end
    #2;
    rstn = 1'b0;
    #1;
    total++;
    if (wr_en !== 1'b0 || busy !== 1'b0 || ack0 !== 1'b0 || reg_addr !== 8'h00) begin
      bad++;
      $display("FAIL rb_async: wr_en=%b busy=%b ack0=%b addr=%h expected 0 0 0 00", wr_en, busy, ack0, reg_addr);
    end
    tick();
    total++;
    if (ack0 !== 1'b0 || wr_en !== 1'b0) begin
      bad++;
      $display("FAIL rb_held: ack0=%b wr_en=%b expected 0 0", ack0, wr_en);
    end
    rstn = 1'b1;
    tick();
    total++;
    if (wr_en !== 1'b1 || owner !== 1'b0 || reg_addr !== 8'h55 || reg_data !== 8'h66) begin
      bad++;
      $display("FAIL rb_regrant: wr_en=%b owner=%b addr=%h data=%h expected 1 0 55 66", wr_en, owner, reg_addr, reg_data);
    end
    wr_done = 1'b1;
    tick();
    wr_done = 1'b0;
    total++;
    if (ack0 !== 1'b1) begin
      bad++;
      $display("FAIL rb_ack: ack0=%b expected 1", ack0);
    end
    req0 = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    logic exp_owner;
    do_reset();
    req0 = 1'b1; ad0 = 16'h1A2B;
    req1 = 1'b1; ad1 = 16'h3C4D;
    for (int i = 0; i < 4; i++) begin
      exp_owner = i[0];
      tick();
      total++;
      if (wr_en !== 1'b1 || owner !== exp_owner ||
          reg_addr !== (exp_owner ? 8'h3C : 8'h1A) || reg_data !== (exp_owner ? 8'h4D : 8'h2B)) begin
        bad++;
        $display("FAIL b2b_grant%0d: wr_en=%b owner=%b addr=%h data=%h expected owner %b",
                 i, wr_en, owner, reg_addr, reg_data, exp_owner);
      end
      tick();
      tick();
      wr_done = 1'b1;
      tick();
      wr_done = 1'b0;
      total++;
      if (wr_en !== 1'b0 || ack0 !== ~exp_owner || ack1 !== exp_owner) begin
        bad++;
        $display("FAIL b2b_done%0d: wr_en=%b ack0=%b ack1=%b expected 0 %b %b",
                 i, wr_en, ack0, ack1, ~exp_owner, exp_owner);
      end
      tick();
      total++;
      if (wr_en !== 1'b0 || busy !== 1'b0 || ack0 !== 1'b0 || ack1 !== 1'b0) begin
        bad++;
        $display("FAIL b2b_gap%0d: wr_en=%b busy=%b ack0=%b ack1=%b expected 0 0 0 0",
                 i, wr_en, busy, ack0, ack1);
      end
      if (i == 3) begin
        req0 = 1'b0;
        req1 = 1'b0;
      end
    end
    tick();
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL b2b_release: busy=%b expected 0", busy);
    end
  endtask

`ifdef SCCB_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int early;
    early = 0;
    req1 = 1'b1; ad1 = 16'h7788;
    tick();
    for (int i = 0; i < 16; i++) begin
      tick();
      if (ack1 !== 1'b0 || wr_en !== 1'b1) early++;
    end
    tick();
    total++;
    if (early != 0 || ack1 !== 1'b1 || err !== 1'b1 || wr_en !== 1'b0) begin
      bad++;
      $display("FAIL timeout_abort: early=%0d ack1=%b err=%b wr_en=%b expected 0 1 1 0", early, ack1, err, wr_en);
    end
    req1 = 1'b0;
    tick();
    req1 = 1'b1;
    tick();
    for (int i = 0; i < 16; i++) tick();
    wr_done = 1'b1;
    tick();
    wr_done = 1'b0;
    total++;
    if (ack1 !== 1'b1 || err !== 1'b0) begin
      bad++;
      $display("FAIL timeout_done_wins: ack1=%b err=%b expected 1 0", ack1, err);
    end
    req1 = 1'b0;
    tick();
  endtask
`else
  task automatic test_timeout();
    int drop;
    drop = 0;
    req1 = 1'b1; ad1 = 16'h7788;
    tick();
    for (int i = 0; i < 40; i++) begin
      tick();
      if (wr_en !== 1'b1 || ack1 !== 1'b0 || err !== 1'b0) drop++;
    end
    total++;
    if (drop != 0 || owner !== 1'b1 || reg_addr !== 8'h77) begin
      bad++;
      $display("FAIL no_timeout_wait: bad=%0d owner=%b addr=%h expected 0 1 77", drop, owner, reg_addr);
    end
    wr_done = 1'b1;
    tick();
    wr_done = 1'b0;
    total++;
    if (ack1 !== 1'b1 || err !== 1'b0 || ack0 !== 1'b0) begin
      bad++;
      $display("FAIL no_timeout_done: ack1=%b err=%b ack0=%b expected 1 0 0", ack1, err, ack0);
    end
    req1 = 1'b0;
    tick();
  endtask
`endif

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_single();
    test_stray_done();
    test_reset_busy();
    test_back_to_back();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
